mem_access_unit: RTL and testbench

- Data-memory responder for the CPU. It executes the 2-bit MemRead/MemWrite codes that the control decoder issues (00 none, 01 byte, 10 half, 11 word).
- Converts each request into one aligned word transaction on a req/ack memory port: byte enables, lane replication for stores, lane select plus sign extension for loads.
- Holds the pipeline with `stall` while the transaction is outstanding.
- Sits between the ALU address output and the register-file write-back mux.

---
 rtl/mem_access_unit.sv | 170 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-memory responder: turns CPU load/store size codes into one aligned word
// transaction on a req/ack port, stalling the pipeline until it completes.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_valid,
   input  logic [1:0]  MemRead,
   input  logic [1:0]  MemWrite,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        load_done,
   output logic        stall,
   output logic        misalign,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt;
   logic             is_load;
   logic [1:0]       size;
   logic [1:0]       lane;

   logic [1:0]  code;
   logic        req_any, illegal, misal, accept, hit_limit;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] load_val;

   // Request decode; only meaningful while in IDLE.
   always_comb begin
      code      = (MemRead != 2'b00) ? MemRead : MemWrite;
      req_any   = cpu_valid && (code != 2'b00);
      illegal   = cpu_valid && (MemRead != 2'b00) && (MemWrite != 2'b00);
      misal     = req_any && !illegal &&
                  (((code == 2'b10) && addr[0]) || ((code == 2'b11) && (addr[1:0] != 2'b00)));
      accept    = req_any && !illegal && !misal;
      hit_limit = (cnt == CNT_W'(TIMEOUT - 1));
   end

   always_comb begin
      be_next    = 4'b1111;
      wdata_next = wdata;
      case (code)
         2'b01: begin
            be_next    = 4'b0001 << addr[1:0];
            wdata_next = {4{wdata[7:0]}};
         end
         2'b10: begin
            be_next    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte  = mem_rdata[{lane, 3'b000} +: 8];
      ld_half  = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      load_val = mem_rdata;
      case (size)
         2'b01:   load_val = {{24{ld_byte[7]}}, ld_byte};
         2'b10:   load_val = {{16{ld_half[15]}}, ld_half};
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Stall is gated by rst so every output reads 0 while reset is held.
   always_comb begin
      state_next = state;
      stall      = 1'b0;
      case (state)
         IDLE: begin
            if (accept && !rst) begin
               stall      = 1'b1;
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            stall = 1'b1;
            if (mem_ack || hit_limit) state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         is_load   <= 1'b0;
         size      <= 2'b00;
         lane      <= 2'b00;
         rdata     <= '0;
         load_done <= 1'b0;
         misalign  <= 1'b0;
         err       <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_be    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         load_done <= 1'b0;
         misalign  <= 1'b0;
         err       <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (illegal) begin
                  err <= 1'b1;
               end else if (misal) begin
                  misalign <= 1'b1;
               end else if (accept) begin
                  mem_req   <= 1'b1;
                  mem_we    <= (MemWrite != 2'b00);
                  mem_be    <= be_next;
                  mem_addr  <= {addr[31:2], 2'b00};
                  mem_wdata <= wdata_next;
                  is_load   <= (MemRead != 2'b00);
                  size      <= code;
                  lane      <= addr[1:0];
               end
            end
            ACCESS: begin
               if (mem_ack || hit_limit) begin
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_be    <= '0;
                  mem_addr  <= '0;
                  mem_wdata <= '0;
               end
               // Ack on the final counted cycle still wins over the timeout.
               if (mem_ack) begin
                  if (is_load) begin
                     rdata     <= load_val;
                     load_done <= 1'b1;
                  end
               end else if (hit_limit) begin
                  err   <= 1'b1;
                  rdata <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_valid;
   logic [1:0]  MemRead, MemWrite;
   logic [31:0] addr, wdata;
   logic [31:0] rdata;
   logic        load_done, stall, misalign, err;
   logic        mem_req, mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;

   int n_vec  = 0;
   int n_fail = 0;

   // Observations collected by run_txn
   logic        o_stall_acc, o_we, o_unstable, o_stall_acc2, o_stall_done;
   logic [3:0]  o_be;
   logic [31:0] o_addr, o_wdata, o_rdata;
   logic        o_load_done, o_err;
   int          o_req;

   mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .cpu_valid(cpu_valid), .MemRead(MemRead), .MemWrite(MemWrite),
      .addr(addr), .wdata(wdata), .rdata(rdata), .load_done(load_done), .stall(stall),
      .misalign(misalign), .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one request, ack on req cycle ack_at (0 = never), record what happens.
   task automatic run_txn(input logic [1:0] rd, input logic [1:0] wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdat, input int ack_at);
      @(negedge clk);
      cpu_valid = 1'b1; MemRead = rd; MemWrite = wr; addr = a; wdata = wd; mem_ack = 1'b0;
      #1 o_stall_acc = stall;
      @(negedge clk);
      cpu_valid = 1'b0; MemRead = 2'b00; MemWrite = 2'b00;
      o_be = mem_be; o_addr = mem_addr; o_we = mem_we; o_wdata = mem_wdata;
      o_req = 0; o_unstable = 1'b0; o_stall_acc2 = 1'b1;
      while (mem_req && o_req < 40) begin
         o_req++;
         if (!stall) o_stall_acc2 = 1'b0;
         if (mem_be !== o_be || mem_addr !== o_addr || mem_wdata !== o_wdata) o_unstable = 1'b1;
         mem_ack = (o_req == ack_at);
         mem_rdata = (o_req == ack_at) ? rdat : 32'h5555_5555;
         @(negedge clk);
      end
      mem_ack = 1'b0;
      o_rdata = rdata; o_load_done = load_done; o_err = err; o_stall_done = stall;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; cpu_valid = 1'b1; MemRead = 2'b11; MemWrite = 2'b00;
      addr = 32'h100; wdata = 32'hFFFF_FFFF; mem_ack = 1'b0; mem_rdata = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      #1;
      n_vec++;
      if ({rdata, load_done, stall, misalign, err, mem_req, mem_we, mem_be, mem_addr, mem_wdata}
          !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: stall=%b mem_req=%b rdata=%h, all required 0",
                  stall, mem_req, rdata);
      end
      @(negedge clk);
      rst = 1'b0; cpu_valid = 1'b0; MemRead = 2'b00;
   endtask

   task automatic test_lw;
      run_txn(2'b11, 2'b00, 32'h100, 32'h0, 32'hDEAD_BEEF, 1);
      n_vec++; if (o_stall_acc !== 1'b1) begin n_fail++;
         $display("FAIL lw_stall_accept: got %b want 1", o_stall_acc); end
      n_vec++; if (o_be !== 4'b1111) begin n_fail++;
         $display("FAIL lw_be: got %b want 1111", o_be); end
      n_vec++; if (o_addr !== 32'h100 || o_we !== 1'b0) begin n_fail++;
         $display("FAIL lw_addr_we: got %h/%b want 00000100/0", o_addr, o_we); end
      n_vec++; if (o_req !== 1 || o_stall_acc2 !== 1'b1) begin n_fail++;
         $display("FAIL lw_req_cycles: got %0d stall=%b want 1 stall=1", o_req, o_stall_acc2); end
      n_vec++; if (o_rdata !== 32'hDEAD_BEEF || o_load_done !== 1'b1) begin n_fail++;
         $display("FAIL lw_result: got %h done=%b want deadbeef done=1", o_rdata, o_load_done); end
      n_vec++; if (o_stall_done !== 1'b0 || o_err !== 1'b0) begin n_fail++;
         $display("FAIL lw_done_stall: got stall=%b err=%b want 0/0", o_stall_done, o_err); end
   endtask

   task automatic test_sub_word_loads;
      run_txn(2'b01, 2'b00, 32'h103, 32'h0, 32'h80FF_FFFF, 1);
      n_vec++; if (o_be !== 4'b1000) begin n_fail++;
         $display("FAIL lb_be: got %b want 1000", o_be); end
      n_vec++; if (o_rdata !== 32'hFFFF_FF80 || o_load_done !== 1'b1) begin n_fail++;
         $display("FAIL lb_rdata: got %h want ffffff80", o_rdata); end
      run_txn(2'b10, 2'b00, 32'h102, 32'h0, 32'h7ABC_0000, 1);
      n_vec++; if (o_be !== 4'b1100 || o_addr !== 32'h100) begin n_fail++;
         $display("FAIL lh_be: got %b/%h want 1100/00000100", o_be, o_addr); end
      n_vec++; if (o_rdata !== 32'h0000_7ABC) begin n_fail++;
         $display("FAIL lh_rdata: got %h want 00007abc", o_rdata); end
   endtask

   task automatic test_stores;
      run_txn(2'b00, 2'b01, 32'h201, 32'h1234_56AA, 32'h0, 1);
      n_vec++; if (o_we !== 1'b1 || o_be !== 4'b0010 || o_addr !== 32'h200) begin n_fail++;
         $display("FAIL sb_ctrl: got we=%b be=%b addr=%h want 1/0010/00000200", o_we, o_be, o_addr); end
      n_vec++; if (o_wdata !== 32'hAAAA_AAAA) begin n_fail++;
         $display("FAIL sb_wdata: got %h want aaaaaaaa", o_wdata); end
      n_vec++; if (o_load_done !== 1'b0 || o_rdata !== 32'h0000_7ABC) begin n_fail++;
         $display("FAIL sb_no_load: got done=%b rdata=%h want 0/00007abc", o_load_done, o_rdata); end
      run_txn(2'b00, 2'b10, 32'h202, 32'h0000_BEEF, 32'h0, 2);
      n_vec++; if (o_be !== 4'b1100 || o_wdata !== 32'hBEEF_BEEF) begin n_fail++;
         $display("FAIL sh_lanes: got be=%b wdata=%h want 1100/beefbeef", o_be, o_wdata); end
      n_vec++; if (o_req !== 2 || o_unstable !== 1'b0 || o_load_done !== 1'b0) begin n_fail++;
         $display("FAIL sh_hold: got req=%0d unstable=%b done=%b want 2/0/0",
                  o_req, o_unstable, o_load_done); end
   endtask

   task automatic test_faults;
      @(negedge clk);
      cpu_valid = 1'b1; MemRead = 2'b11; MemWrite = 2'b00; addr = 32'h102;
      #1;
      n_vec++; if (stall !== 1'b0) begin n_fail++;
         $display("FAIL misalign_stall: got %b want 0", stall); end
      @(negedge clk);
      cpu_valid = 1'b0; MemRead = 2'b00;
      n_vec++; if (misalign !== 1'b1 || mem_req !== 1'b0) begin n_fail++;
         $display("FAIL misalign_pulse: got mis=%b req=%b want 1/0", misalign, mem_req); end
      @(negedge clk);
      n_vec++; if (misalign !== 1'b0 || mem_req !== 1'b0) begin n_fail++;
         $display("FAIL misalign_clear: got mis=%b req=%b want 0/0", misalign, mem_req); end
      cpu_valid = 1'b1; MemRead = 2'b01; MemWrite = 2'b01; addr = 32'h100;
      #1;
      n_vec++; if (stall !== 1'b0) begin n_fail++;
         $display("FAIL illegal_stall: got %b want 0", stall); end
      @(negedge clk);
      cpu_valid = 1'b0; MemRead = 2'b00; MemWrite = 2'b00;
      n_vec++; if (err !== 1'b1 || mem_req !== 1'b0 || misalign !== 1'b0) begin n_fail++;
         $display("FAIL illegal_err: got err=%b req=%b want 1/0", err, mem_req); end
      @(negedge clk);
   endtask

   task automatic test_timeout;
      run_txn(2'b11, 2'b00, 32'h300, 32'h0, 32'h0, 0);
      n_vec++; if (o_req !== 16) begin n_fail++;
         $display("FAIL timeout_req_cycles: got %0d want 16", o_req); end
      n_vec++; if (o_err !== 1'b1 || o_rdata !== 32'h0 || o_load_done !== 1'b0) begin n_fail++;
         $display("FAIL timeout_abort: got err=%b rdata=%h done=%b want 1/00000000/0",
                  o_err, o_rdata, o_load_done); end
      run_txn(2'b11, 2'b00, 32'h304, 32'h0, 32'h1122_3344, 16);
      n_vec++; if (o_req !== 16 || o_err !== 1'b0) begin n_fail++;
         $display("FAIL late_ack_req: got req=%0d err=%b want 16/0", o_req, o_err); end
      n_vec++; if (o_rdata !== 32'h1122_3344 || o_load_done !== 1'b1) begin n_fail++;
         $display("FAIL late_ack_data: got %h done=%b want 11223344/1", o_rdata, o_load_done); end
   endtask

   task automatic test_reset_mid_access;
      @(negedge clk);
      cpu_valid = 1'b1; MemRead = 2'b11; MemWrite = 2'b00; addr = 32'h400;
      @(negedge clk);
      cpu_valid = 1'b0; MemRead = 2'b00;
      @(negedge clk);
      n_vec++; if (mem_req !== 1'b1) begin n_fail++;
         $display("FAIL midreset_pre: got req=%b want 1", mem_req); end
      rst = 1'b1;
      #1;
      n_vec++; if (mem_req !== 1'b0 || stall !== 1'b0) begin n_fail++;
         $display("FAIL midreset_drop: got req=%b stall=%b want 0/0", mem_req, stall); end
      @(negedge clk);
      rst = 1'b0;
      run_txn(2'b11, 2'b00, 32'h404, 32'h0, 32'hCAFE_F00D, 1);
      n_vec++; if (o_req !== 1 || o_rdata !== 32'hCAFE_F00D || o_load_done !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_recover: got req=%0d rdata=%h done=%b want 1/cafef00d/1",
                  o_req, o_rdata, o_load_done);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sub_word_loads();
      test_stores();
      test_faults();
      test_timeout();
      test_reset_mid_access();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
